ccb_bus_arbiter: RTL and testbench

//  Round-robin arbiter for the shared core communication bus (coreComBus) driven by N coreSet instances.

---
 rtl/ccb_pkg.sv | 15 +
 rtl/ccb_bus_arbiter_if.sv | 23 ++
 rtl/ccb_rr_picker.sv | 29 ++
 rtl/ccb_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_ccb_bus_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ccb_pkg.sv
// Shared definitions for the core communication bus arbiter: arag status codes and FSM states.
package ccb_pkg;

   localparam logic [1:0] ARAG_IDLE    = 2'b00;
   localparam logic [1:0] ARAG_WAIT    = 2'b01;
   localparam logic [1:0] ARAG_OWNER   = 2'b10;
   localparam logic [1:0] ARAG_REVOKED = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      TURN  = 2'b10
   } state_e;

endpackage : ccb_pkg

// File: rtl/ccb_bus_arbiter_if.sv
// Request/grant bundle between the coreSet array (master) and the bus arbiter (slave).
interface ccb_bus_arbiter_if #(
   parameter int N_CORES = 2
);

   logic [N_CORES-1:0]   req;
   logic [N_CORES-1:0]   done;
   logic [N_CORES-1:0]   grant;
   logic [2*N_CORES-1:0] arag;
   logic                 busy;
   logic                 timeout;

   modport master (
      output req, done,
      input  grant, arag, busy, timeout
   );

   modport slave (
      input  req, done,
      output grant, arag, busy, timeout
   );

endinterface : ccb_bus_arbiter_if

// File: rtl/ccb_rr_picker.sv
// Combinational rotate-priority picker: first eligible core after last_winner, wrapping around.
module ccb_rr_picker #(
   parameter int N_CORES = 2,
   parameter int IDX_W   = 1
) (
   input  logic [N_CORES-1:0] req_eff_i,
   input  logic [IDX_W-1:0]   last_winner_i,
   output logic [N_CORES-1:0] pick_o,
   output logic               valid_o
);

   int idx;

   // NOTE: every output gets a default before the loop, so no path leaves a value held (no latch).
   always_comb begin
      pick_o  = '0;
      valid_o = 1'b0;
      idx     = 0;
      // Offsets 1..N so the last winner is considered last, making a lone requester win again.
      for (int off = 1; off <= N_CORES; off++) begin
         idx = (int'(last_winner_i) + off) % N_CORES;
         if (!valid_o && req_eff_i[idx]) begin
            pick_o[idx] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule : ccb_rr_picker

// File: rtl/ccb_bus_arbiter.sv
// Round-robin owner arbitration for coreComBus with a one-cycle turnaround between owners.
// Define CCB_TIMEOUT_EN to enable the hold counter and forced revoke after HOLD_MAX grant cycles.
module ccb_bus_arbiter
   import ccb_pkg::*;
#(
   parameter int N_CORES  = 2,
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic               fastClk,
   input  logic               rst,
   ccb_bus_arbiter_if.slave   bus
);

   localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   if ((N_CORES < 2) || (N_CORES > 8) || (HOLD_MAX < 2) || ((2 ** CNT_W) <= HOLD_MAX)) begin : g_bad_cfg
      $error("ccb_bus_arbiter: unsupported N_CORES/HOLD_MAX/CNT_W combination");
   end

   state_e             state_q, state_d;
   logic [N_CORES-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [N_CORES-1:0] req_eff;
   logic [N_CORES-1:0] revoked;
   logic [N_CORES-1:0] pick;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic               owner_release;
   logic               expire;

   // The owner is always last_q while in GRANT; done bits of other cores never reach the FSM.
   assign owner_release = bus.done[last_q] | ~bus.req[last_q];

`ifdef CCB_TIMEOUT_EN
   logic [CNT_W-1:0]   hold_q, hold_d;
   logic [N_CORES-1:0] revoked_q, revoked_d;
   logic               timeout_q;

   // A release in the same cycle as the limit is a normal release, never a revoke.
   assign expire = (state_q == GRANT) && (hold_q == CNT_W'(HOLD_MAX - 1)) && !owner_release;

   always_comb begin
      hold_d = '0;
      if (state_q == GRANT) begin
         hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
      end
      revoked_d = revoked_q & bus.req;
      if (expire) begin
         revoked_d[last_q] = 1'b1;
      end
   end

   always_ff @(posedge fastClk) begin
      if (rst) begin
         hold_q    <= '0;
         revoked_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         revoked_q <= revoked_d;
         timeout_q <= expire;
      end
   end

   assign revoked     = revoked_q;
   assign bus.timeout = timeout_q;
`else
   assign expire      = 1'b0;
   assign revoked     = '0;
   assign bus.timeout = 1'b0;
`endif

   assign req_eff = bus.req & ~revoked;

   ccb_rr_picker #(
      .N_CORES (N_CORES),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_eff_i     (req_eff),
      .last_winner_i (last_q),
      .pick_o        (pick),
      .valid_o       (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (pick[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick;
               last_d  = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (owner_release || expire) begin
               grant_d = '0;
               state_d = TURN;
            end
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge fastClk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(N_CORES - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // REVOKED is shown only while the core still requests, so it clears the moment req drops.
   always_comb begin
      bus.arag = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (revoked[i] && bus.req[i]) begin
            bus.arag[2*i +: 2] = ARAG_REVOKED;
         end else if (grant_q[i]) begin
            bus.arag[2*i +: 2] = ARAG_OWNER;
         end else if (bus.req[i]) begin
            bus.arag[2*i +: 2] = ARAG_WAIT;
         end else begin
            bus.arag[2*i +: 2] = ARAG_IDLE;
         end
      end
   end

   assign bus.grant = grant_q;
   assign bus.busy  = (state_q != IDLE);

endmodule : ccb_bus_arbiter

// File: tb/tb_ccb_bus_arbiter.sv
// Directed bench for ccb_bus_arbiter (N_CORES=2, HOLD_MAX=16); revoke steps run only with CCB_TIMEOUT_EN.
module tb_ccb_bus_arbiter;

   logic fastClk = 1'b0;
   logic rst     = 1'b1;
   int   n_cmp   = 0;
   int   n_err   = 0;

   always #5 fastClk = ~fastClk;

   ccb_bus_arbiter_if #(.N_CORES(2)) bus_if ();

   ccb_bus_arbiter #(
      .N_CORES  (2),
      .HOLD_MAX (16),
      .CNT_W    (5)
   ) dut (
      .fastClk (fastClk),
      .rst     (rst),
      .bus     (bus_if)
   );

   task automatic tick();
      @(posedge fastClk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bus_if.req  = 2'b00;
      bus_if.done = 2'b00;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_grant",   32'(bus_if.grant),   32'h0);
      check("rst_arag",    32'(bus_if.arag),    32'h0);
      check("rst_busy",    32'(bus_if.busy),    32'h0);
      check("rst_timeout", 32'(bus_if.timeout), 32'h0);

      // single request: WAIT immediately, owner one edge later
      bus_if.req = 2'b01;
      #1;
      check("t1_wait_arag", 32'(bus_if.arag), 32'h1);
      tick();
      check("t1_grant", 32'(bus_if.grant), 32'h1);
      check("t1_arag",  32'(bus_if.arag),  32'h2);
      check("t1_busy",  32'(bus_if.busy),  32'h1);
      bus_if.req = 2'b00;
      tick();
      check("t1_turn_grant", 32'(bus_if.grant), 32'h0);
      check("t1_turn_busy",  32'(bus_if.busy),  32'h1);
      tick();
      check("t1_idle_busy", 32'(bus_if.busy), 32'h0);

      // two requesters: core0 first, done hands over to core1 after TURN + IDLE
      do_reset();
      bus_if.req = 2'b11;
      tick();
      check("t2_grant0", 32'(bus_if.grant), 32'h1);
      check("t2_arag0",  32'(bus_if.arag),  32'h6);
      bus_if.done = 2'b01;
      tick();
      bus_if.done = 2'b00;
      check("t2_turn_grant",   32'(bus_if.grant),   32'h0);
      check("t2_turn_busy",    32'(bus_if.busy),    32'h1);
      check("t2_turn_timeout", 32'(bus_if.timeout), 32'h0);
      check("t2_turn_arag",    32'(bus_if.arag),    32'h5);
      tick();
      check("t2_idle_grant", 32'(bus_if.grant), 32'h0);
      check("t2_idle_busy",  32'(bus_if.busy),  32'h0);
      tick();
      check("t2_grant1", 32'(bus_if.grant), 32'h2);
      check("t2_arag1",  32'(bus_if.arag),  32'h9);
      bus_if.done = 2'b01;
      tick();
      bus_if.done = 2'b00;
      check("t2_nonowner_done", 32'(bus_if.grant), 32'h2);
      bus_if.done = 2'b10;
      tick();
      bus_if.done = 2'b00;
      tick();
      tick();
      check("t2_wrap_core0", 32'(bus_if.grant), 32'h1);

      // lone requester regrants itself after release
      bus_if.req  = 2'b01;
      bus_if.done = 2'b01;
      tick();
      bus_if.done = 2'b00;
      check("t2_self_turn", 32'(bus_if.grant), 32'h0);
      tick();
      tick();
      check("t2_self_regrant", 32'(bus_if.grant), 32'h1);
      bus_if.req = 2'b00;
      tick();
      tick();

      // reset in grant cycle 5 clears ownership and the pointer
      do_reset();
      bus_if.req = 2'b11;
      tick();
      check("t5_grant", 32'(bus_if.grant), 32'h1);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      check("t5_rst_grant",   32'(bus_if.grant),   32'h0);
      check("t5_rst_busy",    32'(bus_if.busy),    32'h0);
      check("t5_rst_timeout", 32'(bus_if.timeout), 32'h0);
      check("t5_rst_arag",    32'(bus_if.arag),    32'h5);
      rst = 1'b0;
      tick();
      check("t5_core0_wins", 32'(bus_if.grant), 32'h1);
      bus_if.req = 2'b00;
      tick();
      tick();

`ifdef CCB_TIMEOUT_EN
      // forced revoke after 16 grant cycles; masked until req drops
      do_reset();
      bus_if.req = 2'b01;
      tick();
      check("t3_grant", 32'(bus_if.grant), 32'h1);
      for (int i = 0; i < 15; i++) begin
         tick();
         check("t3_hold", 32'({bus_if.grant, bus_if.timeout}), 32'h2);
      end
      tick();
      check("t3_rev_grant",   32'(bus_if.grant),   32'h0);
      check("t3_rev_timeout", 32'(bus_if.timeout), 32'h1);
      check("t3_rev_arag",    32'(bus_if.arag),    32'h3);
      check("t3_rev_busy",    32'(bus_if.busy),    32'h1);
      tick();
      check("t3_pulse_end", 32'(bus_if.timeout), 32'h0);
      check("t3_masked",    32'(bus_if.grant),   32'h0);
      check("t3_idle_arag", 32'(bus_if.arag),    32'h3);
      tick();
      check("t3_still_masked", 32'(bus_if.grant), 32'h0);
      bus_if.req = 2'b00;
      tick();
      check("t3_clear_arag", 32'(bus_if.arag), 32'h0);
      bus_if.req = 2'b01;
      tick();
      check("t3_regrant", 32'(bus_if.grant), 32'h1);

      // done on the limit cycle wins over the revoke
      for (int i = 0; i < 15; i++) tick();
      check("t4_pre_grant", 32'(bus_if.grant), 32'h1);
      bus_if.done = 2'b01;
      tick();
      bus_if.done = 2'b00;
      check("t4_grant",   32'(bus_if.grant),   32'h0);
      check("t4_timeout", 32'(bus_if.timeout), 32'h0);
      check("t4_arag",    32'(bus_if.arag),    32'h1);
      check("t4_busy",    32'(bus_if.busy),    32'h1);
      tick();
      check("t4_no_pulse", 32'(bus_if.timeout), 32'h0);
      bus_if.req = 2'b00;
      tick();
      tick();
`else
      // unbounded ownership; done[1] from a non-owner is ignored
      do_reset();
      bus_if.req = 2'b01;
      tick();
      check("t6_grant", 32'(bus_if.grant), 32'h1);
      for (int i = 0; i < 100; i++) begin
         bus_if.done = (i == 10) ? 2'b10 : 2'b00;
         tick();
         check("t6_hold", 32'({bus_if.grant, bus_if.timeout}), 32'h2);
         check("t6_arag", 32'(bus_if.arag), 32'h2);
      end
      bus_if.done = 2'b00;
      bus_if.req  = 2'b00;
      tick();
      check("t6_release", 32'(bus_if.grant), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_ccb_bus_arbiter
